// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: the CPU MEM stage has default priority; the external
// requester gets a bounded wait and an optional locked burst of up to MAX_BURST accesses.
module dmem_arbiter #(
  parameter int unsigned AW        = 8,
  parameter int unsigned DW        = 8,
  parameter int unsigned MAX_WAIT  = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          ext_req,
  input  logic          ext_wr,
  input  logic          ext_lock,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_gnt,
  output logic          ext_rvalid,
  output logic [DW-1:0] ext_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [15:0]   stall_cnt
);

  localparam int unsigned WCW = $clog2(MAX_WAIT + 1);
  localparam int unsigned BCW = $clog2(MAX_BURST + 1);

  localparam logic [0:0] CPU_OWN = 1'b0;
  localparam logic [0:0] EXT_OWN = 1'b1;

  logic [0:0]     r_state;
  logic [0:0]     w_state_nxt;
  logic [WCW-1:0] r_wait_cnt;
  logic [WCW-1:0] w_wait_nxt;
  logic [BCW-1:0] r_burst_cnt;
  logic [BCW-1:0] w_burst_nxt;
  logic           r_ext_rvalid;
  logic [DW-1:0]  r_ext_rdata;
  logic [15:0]    r_stall_cnt;
  logic           w_gnt;

  // Grant decision; nothing is granted while reset is held
  always_comb begin
    w_gnt = 1'b0;
    if (!rst) begin
      if (r_state == CPU_OWN)
        w_gnt = ext_req & (~cpu_req | (r_wait_cnt == WCW'(MAX_WAIT)));
      else
        w_gnt = ext_req & (~cpu_req | (r_burst_cnt < BCW'(MAX_BURST)));
    end
  end

  // Next state and counters
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_burst_nxt = r_burst_cnt;

    if (~ext_req | w_gnt)
      w_wait_nxt = '0;
    else if (r_wait_cnt != WCW'(MAX_WAIT))
      w_wait_nxt = r_wait_cnt + WCW'(1);

    case (r_state)
      CPU_OWN: begin
        if (w_gnt & ext_lock) begin
          w_state_nxt = EXT_OWN;
          w_burst_nxt = BCW'(1);
        end else begin
          w_burst_nxt = '0;
        end
      end
      EXT_OWN: begin
        if (w_gnt & ext_lock) begin
          if (r_burst_cnt != BCW'(MAX_BURST))
            w_burst_nxt = r_burst_cnt + BCW'(1);
        end else begin
          w_state_nxt = CPU_OWN;
          w_burst_nxt = '0;
          // burst exhausted while the CPU contends: the refused cycle counts as the first wait
          if (ext_req & ~w_gnt)
            w_wait_nxt = WCW'(1);
        end
      end
      default: begin
        w_state_nxt = CPU_OWN;
        w_burst_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= CPU_OWN;
      r_wait_cnt   <= '0;
      r_burst_cnt  <= '0;
      r_ext_rvalid <= 1'b0;
      r_ext_rdata  <= '0;
      r_stall_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_wait_cnt   <= w_wait_nxt;
      r_burst_cnt  <= w_burst_nxt;
      r_ext_rvalid <= w_gnt & ~ext_wr;
      if (w_gnt & ~ext_wr)
        r_ext_rdata <= mem_rdata;
      if (cpu_req & w_gnt & (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  // Memory port mux
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = 1'b0;
    if (w_gnt) begin
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
      mem_we    = ext_wr;
    end else if (!rst) begin
      mem_we    = cpu_req & cpu_wr;
    end
  end

  assign ext_gnt    = w_gnt;
  assign cpu_stall  = cpu_req & w_gnt;
  assign cpu_rdata  = mem_rdata;
  assign ext_rvalid = r_ext_rvalid;
  assign ext_rdata  = r_ext_rdata;
  assign stall_cnt  = r_stall_cnt;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port data-memory arbiter between the CPU MEM stage and an external requester (loader/debug/DMA engine). The CPU has default priority; a wait counter bounds external starvation, and a burst lock lets the external side hold the port for up to MAX_BURST consecutive accesses. When the CPU loses the port, it sees a one-cycle stall per lost access. The arbiter sits between the EX/MEM pipeline register outputs and the data memory.

## Interface
Parameters:
- AW, 8, address width
- DW, 8, data width
- MAX_WAIT, 4, cycles an external request may be refused while the CPU is contending before it is forced through
- MAX_BURST, 4, maximum consecutive external grants under ext_lock while the CPU is contending

Ports (one clock; reset is asynchronous and active-high; clock `clk`, reset `rst`):
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  MEM-stage access valid (memRd or memWr)
- cpu_wr  in  1  CPU write
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_rdata  out  DW  CPU read data (= mem_rdata, combinational)
- cpu_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle
- ext_req  in  1  external access valid, held until ext_gnt
- ext_wr  in  1  external write
- ext_lock  in  1  request to keep ownership for the next access
- ext_addr  in  AW  external address
- ext_wdata  in  DW  external write data
- ext_gnt  out  1  external access performed this cycle (combinational)
- ext_rvalid  out  1  registered: ext_rdata valid (read granted previous cycle)
- ext_rdata  out  DW  registered read data
- mem_we  out  1  to data memory write enable
- mem_addr  out  AW  to data memory address
- mem_wdata  out  DW  to data memory write data
- mem_rdata  in  DW  from data memory (combinational read)
- stall_cnt  out  16  count of cycles with cpu_stall=1; saturates at 16'hFFFF

## Operation
- State machine: CPU_OWN, EXT_OWN. Counters: wait_cnt (0..MAX_WAIT, saturating), burst_cnt (0..MAX_BURST, saturating).
- In CPU_OWN: ext_gnt = ext_req & (~cpu_req | wait_cnt==MAX_WAIT).
- In EXT_OWN: ext_gnt = ext_req & (~cpu_req | burst_cnt<MAX_BURST).
- Port mux: when ext_gnt=1, mem_addr/mem_wdata = ext_*, mem_we = ext_wr. Otherwise mem_addr/mem_wdata = cpu_*, mem_we = cpu_req & cpu_wr.
- cpu_stall = cpu_req & ext_gnt. The stalled CPU re-presents the same access next cycle.
- wait_cnt: cleared on ext_gnt or ~ext_req. Otherwise it increments when ext_req & ~ext_gnt.
- Transitions:
  - CPU_OWN→EXT_OWN on ext_gnt & ext_lock; burst_cnt←1.
  - EXT_OWN, ext_gnt & ext_lock: stay; burst_cnt increments (saturating).
  - EXT_OWN, ext_gnt & ~ext_lock: →CPU_OWN; burst_cnt←0.
  - EXT_OWN, ~ext_req: →CPU_OWN; burst_cnt←0.
  - EXT_OWN, ext_req & ~ext_gnt (burst exhausted, CPU contending): →CPU_OWN; burst_cnt←0, wait_cnt←1.
- ext_rvalid ← ext_gnt & ~ext_wr. ext_rdata ← mem_rdata when ext_gnt & ~ext_wr, otherwise holds.
- stall_cnt increments each cycle cpu_stall=1.
- Same-address collisions need no special handling: accesses are serialized one per cycle.

## Timing
- Reset values: state CPU_OWN, wait_cnt 0, burst_cnt 0, ext_rvalid 0, ext_rdata 0, stall_cnt 0.
- While rst=1: mem_we forced 0, ext_gnt 0, cpu_stall 0.
- Reset mid-burst aborts ownership. A write in the cycle rst asserts is not committed.
- Latency:
  - Grant, stall and mux are zero-latency (same cycle).
  - A granted write commits at the closing edge.
  - Ext read data appears with ext_rvalid exactly one cycle after ext_gnt.
- Worst-case external wait with continuous cpu_req: MAX_WAIT refused cycles, granted on cycle MAX_WAIT+1.
- Worst-case CPU wait during a locked burst: MAX_BURST stalled cycles, then one guaranteed CPU cycle.
- ext_req=1 & cpu_req=0: external granted every cycle (unbounded burst).

## Test plan
- CPU-only traffic: CPU write 0x5A to addr 0x10, then read 0x10 → cpu_rdata=0x5A; cpu_stall never 1; stall_cnt=0.
- Ext read with idle CPU: mem[0x20]=0x33, ext_req read 0x20 → ext_gnt same cycle; next cycle ext_rvalid=1, ext_rdata=0x33.
- Starvation bound (MAX_WAIT=4): cpu_req held 1, ext_req asserted at cycle 0 → ext_gnt=0 for cycles 0–3, =1 at cycle 4; cpu_stall=1 at cycle 4 only; stall_cnt=1.
- Locked burst with CPU contending (MAX_BURST=4): ext_lock=1, ext_req held, writes to 0x00–0x05 → first 4 granted (cpu_stall=1 each), cycle 5 to CPU, then ext wait counting restarts at 1; stall_cnt increments by 4.
- Simultaneous request, ext wins on wait expiry: CPU write 0xAA and ext write 0x55 both to 0x40 → ext write commits first, CPU write next cycle; final mem[0x40]=0xAA.
- Reset mid-burst: assert rst during EXT_OWN with burst_cnt=2 → state CPU_OWN, counters 0, ext_rvalid 0, mem_we 0 immediately (asynchronous), no write committed.
